// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
// The select type is sized to address every output.
package stream_demux_pkg;
    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_slot.sv
// One output lane of the demux: a one-entry beat buffer with its own
// valid/ready handshake and a wrapping count of delivered beats.
module demux_slot #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt,
    output logic             can_load
);
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             deliver;

    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
        return v + 1'b1;
    endfunction

    // The buffer frees up in the same cycle it drains, so a new beat can
    // overwrite a beat that is leaving.
    assign deliver  = vld_p1 && ready;
    assign can_load = !vld_p1 || ready;

    // Stage p1: buffered beat and delivered-beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            cnt_p1  <= '0;
        end else begin
            if (load) begin
                vld_p1  <= 1'b1;
                data_p1 <= load_data;
            end else if (deliver) begin
                vld_p1  <= 1'b0;
            end
            if (deliver)
                cnt_p1 <= wrap_inc(cnt_p1);
        end
    end

    assign valid = vld_p1;
    assign data  = data_p1;
    assign cnt   = cnt_p1;
endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1:4 stream demultiplexer: steers each accepted input beat into
// the one-entry buffer of the output named by in_sel.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [SEL_W-1:0]            in_sel,
    output logic [N_OUT-1:0]            out_valid,
    input  logic [N_OUT-1:0]            out_ready,
    output logic [N_OUT-1:0][WIDTH-1:0] out_data,
    output logic [N_OUT-1:0][CNT_W-1:0] out_cnt
);
    sel_t             sel;
    logic [N_OUT-1:0] can_load;
    logic [N_OUT-1:0] load;
    logic             accept;

    assign sel      = in_sel;
    // Combinational out_ready -> in_ready path through the selected slot.
    assign in_ready = can_load[sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = '0;
        if (accept)
            load[sel] = 1'b1;
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH),
            .CNT_W(CNT_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .load_data(in_data),
            .ready    (out_ready[i]),
            .valid    (out_valid[i]),
            .data     (out_data[i]),
            .cnt      (out_cnt[i]),
            .can_load (can_load[i])
        );
    end
endmodule
